// File: rtl/prog_mem_loader.sv
// 16x8 program/data RAM on the CPU memory port with a byte-stream image loader that holds the CPU in reset until the image is complete.
// Optional checksum stage enabled by defining LOADER_CHECKSUM_EN (adds CHECK/ERR states and drives error).
module prog_mem_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = (1 << ADDR_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] memoryIn,
    output logic [DATA_W-1:0] memoryOut,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, CHECK = 3'd2, RUN = 3'd3, ERR = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd3} state_t;
`endif

    state_t             state_r;
    logic [ADDR_W-1:0]  wptr_r;
    logic [DATA_W-1:0]  sum_r;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               load_wr_s;
    logic               run_wr_s;
    logic               last_s;
    logic [DATA_W-1:0]  sum_next_s;
    logic               mem_we_s;
    logic [ADDR_W-1:0]  mem_wa_s;
    logic [DATA_W-1:0]  mem_wd_s;

    // Write-port arbitration: image bytes in LOAD, CPU stores in RUN (a restart request drops the image byte)
    always_comb begin
        load_wr_s  = (state_r == LOAD) && load_valid && !load_start;
        run_wr_s   = (state_r == RUN) && write;
        last_s     = (wptr_r == ADDR_W'(DEPTH - 1));
        sum_next_s = sum_r + load_data;
        mem_we_s   = 1'b0;
        mem_wa_s   = {ADDR_W{1'b0}};
        mem_wd_s   = {DATA_W{1'b0}};
        if (load_wr_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = wptr_r;
            mem_wd_s = load_data;
        end else if (run_wr_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = address;
            mem_wd_s = memoryIn;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array; deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (!reset && mem_we_s) begin
            mem[mem_wa_s] <= mem_wd_s;
        end
    end

    // Loader FSM with write pointer and running byte sum
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            wptr_r  <= {ADDR_W{1'b0}};
            sum_r   <= {DATA_W{1'b0}};
        end else if (load_start) begin
            state_r <= LOAD;
            wptr_r  <= {ADDR_W{1'b0}};
            sum_r   <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: state_r <= IDLE;
                LOAD: begin
                    if (load_valid) begin
                        wptr_r <= last_s ? {ADDR_W{1'b0}} : wptr_r + ADDR_W'(1);
                        sum_r  <= sum_next_s;
                        if (last_s) begin
`ifdef LOADER_CHECKSUM_EN
                            state_r <= CHECK;
`else
                            state_r <= RUN;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (load_valid) begin
                        state_r <= (sum_next_s == {DATA_W{1'b0}}) ? RUN : ERR;
                    end
                end
                ERR: state_r <= ERR;
`endif
                RUN: state_r <= RUN;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Zero-latency CPU read: the CPU samples memoryOut in the same cycle it raises read
    always_comb begin
        if ((state_r == RUN) && read) begin
            memoryOut = mem[address];
        end else begin
            memoryOut = {DATA_W{1'b0}};
        end
    end

    assign cpu_reset = (state_r != RUN);
    assign done      = (state_r == RUN);
`ifdef LOADER_CHECKSUM_EN
    assign load_ready = (state_r == LOAD) || (state_r == CHECK);
    assign error      = (state_r == ERR);
`else
    assign load_ready = (state_r == LOAD);
    assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader: directed scenarios plus randomized traffic against a byte-count reference model.
// Follows LOADER_CHECKSUM_EN the same way as the design.
module tb_prog_mem_loader;
    logic       clk = 1'b0;
    logic       reset, load_start, load_valid, read, write;
    logic [7:0] load_data, memoryIn, memoryOut;
    logic [3:0] address;
    logic       load_ready, cpu_reset, done, error;

    int n_checks = 0;
    int n_errors = 0;

    localparam int M_IDLE = 0, M_LOAD = 1, M_CHECK = 2, M_RUN = 3, M_ERR = 4;
    int         m_state;
    int         m_cnt;
    logic [7:0] m_sum;
    logic [7:0] m_mem [16];
    bit         m_known = 1'b0;

    always #5 clk = ~clk;

    prog_mem_loader dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .read(read), .write(write),
        .address(address), .memoryIn(memoryIn), .memoryOut(memoryOut),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [7:0] exp_out;
        exp_out = (m_state == M_RUN && read) ? m_mem[address] : 8'h00;
        check_val("load_ready", {31'd0, load_ready}, {31'd0, (m_state == M_LOAD) || (m_state == M_CHECK)});
        check_val("cpu_reset", {31'd0, cpu_reset}, {31'd0, m_state != M_RUN});
        check_val("done", {31'd0, done}, {31'd0, m_state == M_RUN});
        check_val("error", {31'd0, error}, {31'd0, m_state == M_ERR});
        check_val("memoryOut", {24'd0, memoryOut}, {24'd0, exp_out});
    endtask

    // One clock: check the pre-edge outputs, predict the edge, then advance the model
    task automatic tick();
        int         ns, nc;
        logic [7:0] nsum;
        bit         we;
        logic [3:0] wa;
        logic [7:0] wd;
        #2;
        if (m_known) check_all();
        ns = m_state; nc = m_cnt; nsum = m_sum; we = 1'b0; wa = 4'd0; wd = 8'd0;
        if (!reset && m_state == M_RUN && write) begin
            we = 1'b1; wa = address; wd = memoryIn;
        end
        if (reset) begin
            ns = M_IDLE; nc = 0; nsum = 8'h00;
        end else if (load_start) begin
            ns = M_LOAD; nc = 0; nsum = 8'h00;
        end else if (m_state == M_LOAD && load_valid) begin
            we = 1'b1; wa = 4'(m_cnt); wd = load_data;
            nsum = m_sum + load_data;
            nc = m_cnt + 1;
            if (nc == 16) begin
`ifdef LOADER_CHECKSUM_EN
                ns = M_CHECK;
`else
                ns = M_RUN;
`endif
                nc = 0;
            end
        end else if (m_state == M_CHECK && load_valid) begin
            ns = (8'(m_sum + load_data) == 8'h00) ? M_RUN : M_ERR;
        end
        @(posedge clk);
        if (reset) m_known = 1'b1;
        m_state = ns; m_cnt = nc; m_sum = nsum;
        if (we) m_mem[wa] = wd;
        #1;
    endtask

    task automatic load_image(input logic [7:0] base, input bit step, input bit gaps);
        logic [7:0] s;
        s = 8'h00;
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            load_valid = 1'b1; load_data = step ? base + 8'(i) : base; tick();
            s = s + load_data;
            if (gaps) begin
                load_valid = 1'b0; load_data = 8'($urandom); tick();
                if (i < 15) check_val("ready_in_gap", {31'd0, load_ready}, 32'd1);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        load_valid = 1'b1; load_data = 8'h00 - s; tick();
`endif
        load_valid = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [3:0] a, input logic [7:0] exp);
        read = 1'b1; write = 1'b0; address = a; #2;
        check_val(tag, {24'd0, memoryOut}, {24'd0, exp});
        tick();
        read = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00;
        read = 1'b1; write = 1'b0; address = 4'd0; memoryIn = 8'h00;
        m_state = M_IDLE; m_cnt = 0; m_sum = 8'h00;

        // Reset held two cycles, read asserted
        tick(); tick();
        check_val("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_ready", {31'd0, load_ready}, 32'd0);
        check_val("rst_memout", {24'd0, memoryOut}, 32'd0);
        reset = 1'b0; read = 1'b0; tick();

        // Back-to-back image
        load_image(8'h10, 1'b1, 1'b0);
        check_val("img1_done", {31'd0, done}, 32'd1);
        check_val("img1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        peek("img1_rd5", 4'd5, 8'h15);

        // Same image with load_valid toggling
        load_image(8'h10, 1'b1, 1'b1);
        check_val("img2_done", {31'd0, done}, 32'd1);
        for (int a = 0; a < 16; a += 5) peek("img2_rd", 4'(a), 8'h10 + 8'(a));

        // CPU store, then read-during-write
        write = 1'b1; address = 4'd3; memoryIn = 8'hA5; tick(); write = 1'b0;
        peek("wr_rd3", 4'd3, 8'hA5);
        read = 1'b1; write = 1'b1; address = 4'd3; memoryIn = 8'h5A; #2;
        check_val("rw_old", {24'd0, memoryOut}, 32'hA5);
        tick(); write = 1'b0;
        peek("rw_new", 4'd3, 8'h5A);

        // Restart after seven bytes
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 7; i++) begin load_valid = 1'b1; load_data = 8'hC0 + 8'(i); tick(); end
        load_valid = 1'b0;
        load_image(8'h20, 1'b1, 1'b0);
        check_val("restart_done", {31'd0, done}, 32'd1);
        peek("restart_rd0", 4'd0, 8'h20);
        peek("restart_rd15", 4'd15, 8'h2F);

        // Reset after seven bytes
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 7; i++) begin load_valid = 1'b1; load_data = 8'hD0; tick(); end
        load_valid = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
        check_val("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_val("midrst_ready", {31'd0, load_ready}, 32'd0);
        tick();

`ifdef LOADER_CHECKSUM_EN
        load_image(8'h01, 1'b0, 1'b0);
        check_val("ck_good_done", {31'd0, done}, 32'd1);
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 16; i++) begin load_valid = 1'b1; load_data = 8'h01; tick(); end
        load_data = 8'hF1; tick(); load_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_val("ck_bad_error", {31'd0, error}, 32'd1);
        check_val("ck_bad_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        load_start = 1'b1; tick(); load_start = 1'b0;
        check_val("ck_err_exit", {31'd0, error}, 32'd0);
        load_valid = 1'b0; tick();
`endif

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            reset      = ($urandom % 151) == 0;
            load_start = ($urandom % 37) == 0;
            load_valid = $urandom % 2;
            load_data  = 8'($urandom);
            read       = $urandom % 2;
            write      = ($urandom % 4) == 0;
            address    = 4'($urandom);
            memoryIn   = 8'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
